// File: rtl/scan_mux_if.sv
// scan_mux_if: channel inputs, scan controls and sampled outputs for scan_mux.
interface scan_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          sel;
    logic                      sel_load;
    logic                      scan_en;
    logic                      hold;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      ch_wrap;
    logic                      sel_err;
    modport master (
        output in_data, sel, sel_load, scan_en, hold,
        input  out_data, out_ch, out_valid, ch_wrap, sel_err
    );
    modport slave (
        input  in_data, sel, sel_load, scan_en, hold,
        output out_data, out_ch, out_valid, ch_wrap, sel_err
    );
endinterface

// File: rtl/scan_mux.sv
// scan_mux: registered channel mux with manual select and round-robin dwell scan.
module scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4
) (
    input logic       clk,
    input logic       rst_n,
    scan_mux_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    localparam int DW_W  = $clog2(DWELL) + 1;

    logic [SEL_W-1:0] cur_q, cur_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic sel_ok, dwell_last, ch_last;
    assign sel_ok     = 32'(bus.sel) < CHANNELS;
    assign dwell_last = 32'(dwell_q) == DWELL - 1;
    assign ch_last    = 32'(cur_q) == CHANNELS - 1;

    always_comb begin
        cur_d   = cur_q;
        dwell_d = dwell_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (!bus.hold) begin
            data_d  = bus.in_data[32'(cur_q)*WIDTH +: WIDTH];
            ch_d    = cur_q;
            valid_d = 1'b1;
            if (bus.sel_load) begin
                cur_d   = sel_ok ? bus.sel : cur_q;
                dwell_d = sel_ok ? '0 : dwell_q;
                err_d   = !sel_ok;
            end else if (bus.scan_en) begin
                // non-power-of-two channel counts wrap explicitly, not by overflow
                cur_d   = dwell_last ? (ch_last ? '0 : cur_q + 1'b1) : cur_q;
                dwell_d = dwell_last ? '0 : dwell_q + 1'b1;
                wrap_d  = dwell_last && ch_last;
            end else begin
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q   <= '0;
            dwell_q <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.ch_wrap   = wrap_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: random and directed stimulus on a 4-channel/dwell-4 and a 3-channel/dwell-1 mux.
module tb_scan_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_mux_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
    scan_mux_if #(.WIDTH(8), .CHANNELS(3)) ifb ();

    scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        int cur, dw, data, ch;
        bit valid, wrap, err;
    } st_t;

    st_t ma, mb;
    int n_checks = 0;
    int n_errors = 0;

    function automatic st_t nxt(st_t s, int nch, int dwell, bit rn, bit hold, bit load,
                                int sel, bit scan, logic [31:0] din);
        st_t n = s;
        n.wrap = 0;
        n.err  = 0;
        if (!rn) begin
            n = '{default: 0};
            return n;
        end
        if (hold) return n;
        n.data  = int'((din >> (s.cur * 8)) & 32'hff);
        n.ch    = s.cur;
        n.valid = 1;
        if (load) begin
            if (sel < nch) begin
                n.cur = sel;
                n.dw  = 0;
            end else n.err = 1;
        end else if (scan) begin
            if (s.dw == dwell - 1) begin
                n.dw   = 0;
                n.wrap = (s.cur == nch - 1);
                n.cur  = (s.cur + 1) % nch;
            end else n.dw = s.dw + 1;
        end else n.dw = 0;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rn, input bit hold, input bit load, input int sel,
                        input bit scan, input logic [31:0] din);
        rst_n = rn;
        ifa.hold = hold;      ifb.hold = hold;
        ifa.sel_load = load;  ifb.sel_load = load;
        ifa.sel = 2'(sel);    ifb.sel = 2'(sel);
        ifa.scan_en = scan;   ifb.scan_en = scan;
        ifa.in_data = din;    ifb.in_data = din[23:0];
        @(posedge clk);
        ma = nxt(ma, 4, 4, rn, hold, load, sel, scan, din);
        mb = nxt(mb, 3, 1, rn, hold, load, sel, scan, din);
        #1;
        check("a_data", 32'(ifa.out_data), ma.data);
        check("a_ch", 32'(ifa.out_ch), ma.ch);
        check("a_valid", 32'(ifa.out_valid), 32'(ma.valid));
        check("a_wrap", 32'(ifa.ch_wrap), 32'(ma.wrap));
        check("a_err", 32'(ifa.sel_err), 32'(ma.err));
        check("b_data", 32'(ifb.out_data), mb.data);
        check("b_ch", 32'(ifb.out_ch), mb.ch);
        check("b_valid", 32'(ifb.out_valid), 32'(mb.valid));
        check("b_wrap", 32'(ifb.ch_wrap), 32'(mb.wrap));
        check("b_err", 32'(ifb.sel_err), 32'(mb.err));
    endtask

    initial begin
        int wraps;
        bit scan;
        ma = '{default: 0};
        mb = '{default: 0};
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 1, 1, 2, 1, 32'hdeadbeef);
        check("rst_valid", 32'(ifa.out_valid), 0);
        check("rst_data", 32'(ifa.out_data), 0);
        // first edge after release samples channel 0
        step(1, 0, 0, 0, 0, 32'h44332211);
        check("first_valid", 32'(ifa.out_valid), 1);
        check("first_data", 32'(ifa.out_data), 32'h11);
        check("first_ch", 32'(ifa.out_ch), 0);
        step(1, 0, 1, 2, 0, 32'h44332211);
        check("load_old_data", 32'(ifa.out_data), 32'h11);
        step(1, 0, 0, 0, 0, 32'h44332211);
        check("load_new_data", 32'(ifa.out_data), 32'h33);
        check("load_new_ch", 32'(ifa.out_ch), 2);
        // channel 3 is out of range for the 3-channel instance
        step(1, 0, 1, 3, 0, 32'h44332211);
        check("b_sel_err", 32'(ifb.sel_err), 1);
        step(1, 0, 0, 0, 0, 32'h44332211);
        check("b_sel_err_clr", 32'(ifb.sel_err), 0);
        check("b_ch_kept", 32'(ifb.out_ch), 2);
        step(1, 0, 1, 0, 1, 32'h44332211);
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 1, 32'h44332211);
            wraps += int'(ifa.ch_wrap);
        end
        check("wrap_per_16", wraps, 1);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 1, $urandom);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 1, $urandom);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, $urandom);
        step(1, 1, 0, 0, 1, $urandom);
        step(0, 1, 1, 2, 1, $urandom);
        check("rst_hold_ch", 32'(ifa.out_ch), 0);
        check("rst_hold_valid", 32'(ifa.out_valid), 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, $urandom);
        scan = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) scan = !scan;
            step($urandom_range(0, 49) != 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)), scan, $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the data bits per channel (>=1).
REQ-002 The parameter CHANNELS SHALL default to 4 and set the input channel count (>=2).
REQ-003 The parameter DWELL SHALL default to 4 and set the cycles spent on each channel in scan mode (>=1).
REQ-004 The localparam SEL_W SHALL be derived as clog2(CHANNELS), minimum 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  channel index, used when sel_load=1.
REQ-009 sel_load  input  1  loads sel into the active-channel register.
REQ-010 scan_en  input  1  0 = manual mode, 1 = automatic round-robin scan.
REQ-011 hold  input  1  freezes all internal state and outputs.
REQ-012 out_data  output  WIDTH  registered data of the sampled channel.
REQ-013 out_ch  output  SEL_W  index of the channel that produced out_data.
REQ-014 out_valid  output  1  out_data/out_ch are meaningful.
REQ-015 ch_wrap  output  1  one-cycle pulse when the scan wraps from CHANNELS-1 to 0.
REQ-016 sel_err  output  1  one-cycle pulse when a sel_load carries sel >= CHANNELS.

Function
REQ-017 Internal state SHALL be cur_ch (SEL_W bits) and dwell_cnt (clog2(DWELL)+1 bits).
REQ-018 Each edge with hold=0 SHALL load out_data with the in_data slice of the pre-edge cur_ch and load out_ch with that pre-edge cur_ch.
REQ-019 Data latency SHALL be 1 cycle: in_data sampled at edge k is visible on out_data after edge k.
REQ-020 Select latency SHALL be 2 cycles: a sel_load sampled at edge k updates cur_ch at edge k, and out_data first shows the new channel after edge k+1.
REQ-021 Update priority per edge SHALL be: reset, then hold, then sel_load, then scan advance.
REQ-022 With hold=1, cur_ch, dwell_cnt, out_data, out_ch and out_valid SHALL keep their values, sel_load SHALL be ignored, and ch_wrap and sel_err SHALL be 0.
REQ-023 For sel_load=1 with sel < CHANNELS, the block SHALL set cur_ch to sel and clear dwell_cnt, in either mode.
REQ-024 For sel_load=1 with sel >= CHANNELS, cur_ch and dwell_cnt SHALL be unchanged and sel_err SHALL pulse high for the following cycle.
REQ-025 Manual mode (scan_en=0) SHALL keep dwell_cnt at 0 and SHALL change cur_ch only through sel_load.
REQ-026 Scan mode without a load SHALL increment dwell_cnt while dwell_cnt < DWELL-1.
REQ-027 Scan mode without a load, at dwell_cnt = DWELL-1, SHALL clear dwell_cnt and advance cur_ch by one.
REQ-028 An advance from CHANNELS-1 SHALL wrap cur_ch to 0 and pulse ch_wrap for exactly one cycle, including when CHANNELS is not a power of two.
REQ-029 With DWELL=1, scan mode SHALL advance cur_ch on every edge.
REQ-030 A 0->1 transition of scan_en SHALL start dwelling on the current cur_ch with dwell_cnt=0, so the first advance occurs DWELL edges later.
REQ-031 A 1->0 transition of scan_en SHALL freeze cur_ch at its current value.
REQ-032 out_valid SHALL rise at the first non-hold edge after rst_n goes high and then stay 1 until reset.

Reset
REQ-033 An edge with rst_n=0 SHALL set cur_ch=0, dwell_cnt=0, out_data=0, out_ch=0, out_valid=0, ch_wrap=0 and sel_err=0, overriding hold and sel_load.
REQ-034 Reset asserted mid-scan or mid-hold SHALL take effect at the same edge, with no residual pulse after release.

Verification
REQ-035 Release reset with defaults, scan_en=0 and in_data=0x44332211 -> out_valid=1, out_data=0x11, out_ch=0 after the first edge.
REQ-036 Manual load of sel=2 at edge k -> out_data=0x33 and out_ch=2 after edge k+1, with old channel 0 data still shown after edge k.
REQ-037 scan_en=1, DWELL=4, CHANNELS=4 -> out_ch follows the sequence 0,0,0,0,1,1,1,1,2,... and ch_wrap pulses once every 16 cycles on the 3->0 advance.
REQ-038 CHANNELS=3: load of sel=3 -> sel_err pulses for 1 cycle and cur_ch is unchanged; in scan mode cur_ch wraps 2->0.
REQ-039 Assert hold for 5 cycles mid-dwell -> outputs and dwell position are frozen, and the scan resumes on the same count after hold drops.
REQ-040 Assert rst_n=0 during scan with hold=1 -> all outputs are 0 after that edge, and scanning restarts from channel 0 after release.
